led_seq_ctrl: RTL and testbench
===============================

Name: led_seq_ctrl

Overview:
Write scheduler and pattern engine in front of the 24-bit LED output peripheral. It shares the peripheral's single write port between CPU full-width update requests and an autonomous blink/rotate pattern engine. Each 24-bit update is split into the peripheral's two-write protocol: low 16 bits at addr 2'b00, then the high 8 bits at addr 2'b10. It sits between the memory/IO decode logic and the LED peripheral.

Parameters:
DIV_W, 16, width of the pattern tick divider input and counter.

Ports:
clk  in  1  system clock; all state updates on posedge.
ledrst  in  1  reset, asynchronous, active-high.
cpu_req  in  1  level request to write cpu_data; held until cpu_ack.
cpu_data  in  24  full LED value {R[23:16], Y[15:8], G[7:0]}.
cpu_ack  out  1  one-cycle pulse; request captured.
mode  in  2  00 static, 01 blink, 10 rotate, 11 treated as static.
tick_div  in  DIV_W  pattern period in clk cycles; 0 disables the engine.
led_cs  out  1  chip select to the LED peripheral.
led_write  out  1  write strobe to the LED peripheral.
led_addr  out  2  peripheral address: 2'b00 low half, 2'b10 high byte.
led_wdata  out  16  peripheral write data.
busy  out  1  1 while in WR_LO or WR_HI.
tick_miss  out  1  sticky; a tick arrived while the previous tick was still pending.

Behaviour:
- All outputs are registered. The peripheral samples on negedge, so data is stable mid-cycle.
- Reset state:
  - FSM in IDLE.
  - led_cs, led_write, cpu_ack, busy, tick_miss = 0.
  - led_addr = 2'b00, led_wdata = 0.
  - Internal registers base, pat, shadow = 0; phase = 1; div counter = 0; tick_pend = 0.
- Reset mid-update abandons the update. The peripheral resets with the same signal, so shadow = 0 stays consistent with it.
- Divider:
  - Counts only while mode is 01 or 10 and tick_div != 0. Otherwise the counter is held at 0.
  - At count == tick_div-1: count goes to 0 and a tick fires. The period is tick_div cycles; tick_div = 1 gives a tick every cycle.
  - A tick sets tick_pend. If tick_pend is already 1, the tick is dropped and tick_miss is set.
- FSM states: IDLE, WR_LO, WR_HI.
- IDLE with cpu_req = 1 (priority over tick_pend):
  - base <= cpu_data, pat <= cpu_data, phase <= 1, nxt <= cpu_data.
  - cpu_ack pulses in the following cycle, coincident with the first WR_LO cycle.
  - Go to WR_LO.
- IDLE with no cpu_req, tick_pend = 1 and mode is 01 or 10:
  - tick_pend cleared. Same-cycle tick: pending is cleared, then set again.
  - Blink: phase <= ~phase; nxt = (~phase) ? base : 24'h0.
  - Rotate: pat <= {pat[22:0], pat[23]}; nxt = rotated value.
  - Go to WR_LO.
- IDLE with tick_pend = 1 and mode static: tick_pend cleared, no write.
- WR_LO (1 cycle):
  - led_cs = led_write = 1, led_addr = 00, led_wdata = nxt[15:0].
  - Go to WR_HI.
- WR_HI (1 cycle):
  - led_cs = led_write = 1, led_addr = 10, led_wdata = {8'h00, nxt[23:16]}.
  - shadow <= nxt; go to IDLE.
- In IDLE: led_cs = led_write = 0; led_addr and led_wdata hold their last values.
- busy = 1 in WR_LO and WR_HI.
- Requests arriving while busy wait. A CPU request and a tick in the same IDLE cycle: CPU served, tick stays pending.
- Throughput: one 24-bit update per 3 cycles (IDLE, WR_LO, WR_HI).
- The mode value is sampled when the tick is served. A mode change does not reset phase or pat.

Optional Feature:
LED_SEQ_SKIP_HI_EN:
- Defined: in WR_LO, if nxt[23:16] == shadow[23:16], WR_HI is skipped. shadow is updated in WR_LO and the FSM returns to IDLE, giving a 2-cycle update.
- Undefined: WR_HI is always issued.

Test Plan:
1. Reset, then cpu_req with cpu_data = 24'hA5_1234:
   - cpu_ack pulses once.
   - Next two cycles: (cs=1, addr=00, wdata=16'h1234), then (cs=1, addr=10, wdata=16'h00A5).
   - Then cs=0, busy=0.
2. mode = 01, tick_div = 4, base = 24'h00_00FF:
   - Writes occur every 4 cycles, alternating value 0 and 24'h0000FF (first tick writes 0).
3. mode = 10, tick_div = 3, CPU writes 24'h80_0001:
   - Successive tick writes are 24'h00_0003, 24'h00_0006, 24'h00_000C (wdata low/high checked).
4. cpu_req asserted in the same IDLE cycle as tick_pend:
   - CPU value written first.
   - Tick write follows immediately after WR_HI, using the new base/pat.
5. tick_div = 1, mode = 10:
   - tick_miss rises within 3 cycles and stays 1 until ledrst.
   - Assert ledrst during WR_LO: all outputs return to 0 asynchronously.
6. With LED_SEQ_SKIP_HI_EN: write 24'h11_0000, then 24'h11_2222:
   - Second update issues only the addr=00 write (wdata 16'h2222), busy for 1 cycle.
   - Without the macro, both writes are issued.

Source files
------------

// File: rtl/led_seq_ctrl.sv
// Write scheduler for the 24-bit LED peripheral: CPU updates and a blink/rotate pattern engine share one
// write port, each update split into low-half (addr 00) and high-byte (addr 10) writes. Option: LED_SEQ_SKIP_HI_EN.
module led_seq_ctrl #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             ledrst,
    input  logic             cpu_req,
    input  logic [23:0]      cpu_data,
    output logic             cpu_ack,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] tick_div,
    output logic             led_cs,
    output logic             led_write,
    output logic [1:0]       led_addr,
    output logic [15:0]      led_wdata,
    output logic             busy,
    output logic             tick_miss
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WR_LO = 2'b01,
        ST_WR_HI = 2'b10
    } state_t;

    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

    state_t             state_r, state_s;
    logic [23:0]        base_r, base_s, pat_r, pat_s, shadow_r, shadow_s, nxt_r, nxt_s;
    logic               phase_r, phase_s;
    logic [DIV_W-1:0]   div_cnt_r, div_cnt_s;
    logic               tick_pend_r, tick_pend_s, tick_miss_s;
    logic               pat_mode_s, div_run_s, tick_s, clr_pend_s;
    logic               cs_s, ack_s, busy_s;
    logic [1:0]         addr_s;
    logic [15:0]        wdata_s;

    function automatic logic [23:0] rotl1(input logic [23:0] v);
        return {v[22:0], v[23]};
    endfunction

    // Pattern tick divider; >= lets a shrinking tick_div wrap at once instead of running to overflow
    always_comb begin
        pat_mode_s = (mode == 2'b01) || (mode == 2'b10);
        div_run_s  = pat_mode_s && (tick_div != DIV_ZERO);
        tick_s     = 1'b0;
        div_cnt_s  = DIV_ZERO;
        if (div_run_s) begin
            if (div_cnt_r >= (tick_div - DIV_ONE)) begin
                tick_s    = 1'b1;
                div_cnt_s = DIV_ZERO;
            end else begin
                div_cnt_s = div_cnt_r + DIV_ONE;
            end
        end else begin
            div_cnt_s = DIV_ZERO;
        end
    end

    // Scheduler FSM: next state, update value and next registered peripheral outputs
    always_comb begin
        state_s    = state_r;
        base_s     = base_r;
        pat_s      = pat_r;
        phase_s    = phase_r;
        nxt_s      = nxt_r;
        shadow_s   = shadow_r;
        clr_pend_s = 1'b0;
        ack_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cpu_req) begin
                    base_s  = cpu_data;
                    pat_s   = cpu_data;
                    phase_s = 1'b1;
                    nxt_s   = cpu_data;
                    ack_s   = 1'b1;
                    state_s = ST_WR_LO;
                end else if (tick_pend_r) begin
                    clr_pend_s = 1'b1;
                    case (mode)
                        2'b01: begin
                            phase_s = ~phase_r;
                            nxt_s   = phase_r ? 24'h00_0000 : base_r;
                            state_s = ST_WR_LO;
                        end
                        2'b10: begin
                            pat_s   = rotl1(pat_r);
                            nxt_s   = rotl1(pat_r);
                            state_s = ST_WR_LO;
                        end
                        default: state_s = ST_IDLE;
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WR_LO: begin
`ifdef LED_SEQ_SKIP_HI_EN
                // Peripheral already holds this high byte, so the update completes with the low write
                if (nxt_r[23:16] == shadow_r[23:16]) begin
                    shadow_s = nxt_r;
                    state_s  = ST_IDLE;
                end else begin
                    state_s  = ST_WR_HI;
                end
`else
                state_s = ST_WR_HI;
`endif
            end
            ST_WR_HI: begin
                shadow_s = nxt_r;
                state_s  = ST_IDLE;
            end
            default: state_s = ST_IDLE;
        endcase

        cs_s    = 1'b0;
        busy_s  = 1'b0;
        addr_s  = led_addr;
        wdata_s = led_wdata;
        case (state_s)
            ST_WR_LO: begin
                cs_s    = 1'b1;
                busy_s  = 1'b1;
                addr_s  = 2'b00;
                wdata_s = nxt_s[15:0];
            end
            ST_WR_HI: begin
                cs_s    = 1'b1;
                busy_s  = 1'b1;
                addr_s  = 2'b10;
                wdata_s = {8'h00, nxt_s[23:16]};
            end
            default: begin
                cs_s    = 1'b0;
                busy_s  = 1'b0;
            end
        endcase

        // A tick landing in the serving cycle re-arms pending rather than counting as a miss
        tick_pend_s = (tick_pend_r && !clr_pend_s) || tick_s;
        tick_miss_s = tick_miss || (tick_s && tick_pend_r && !clr_pend_s);
    end

    // State, pattern registers and registered peripheral outputs
    always_ff @(posedge clk or posedge ledrst) begin
        if (ledrst) begin
            state_r     <= ST_IDLE;
            base_r      <= 24'h00_0000;
            pat_r       <= 24'h00_0000;
            shadow_r    <= 24'h00_0000;
            nxt_r       <= 24'h00_0000;
            phase_r     <= 1'b1;
            div_cnt_r   <= DIV_ZERO;
            tick_pend_r <= 1'b0;
            tick_miss   <= 1'b0;
            cpu_ack     <= 1'b0;
            led_cs      <= 1'b0;
            led_write   <= 1'b0;
            led_addr    <= 2'b00;
            led_wdata   <= 16'h0000;
            busy        <= 1'b0;
        end else begin
            state_r     <= state_s;
            base_r      <= base_s;
            pat_r       <= pat_s;
            shadow_r    <= shadow_s;
            nxt_r       <= nxt_s;
            phase_r     <= phase_s;
            div_cnt_r   <= div_cnt_s;
            tick_pend_r <= tick_pend_s;
            tick_miss   <= tick_miss_s;
            cpu_ack     <= ack_s;
            led_cs      <= cs_s;
            led_write   <= cs_s;
            led_addr    <= addr_s;
            led_wdata   <= wdata_s;
            busy        <= busy_s;
        end
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl: per-cycle vector table for CPU/blink traffic, hand sequences
// for rotate, arbitration, tick overrun, async reset and the optional high-byte skip.
module tb_led_seq_ctrl;

    logic        clk = 1'b0;
    logic        ledrst;
    logic        cpu_req;
    logic [23:0] cpu_data;
    logic        cpu_ack;
    logic [1:0]  mode;
    logic [15:0] tick_div;
    logic        led_cs;
    logic        led_write;
    logic [1:0]  led_addr;
    logic [15:0] led_wdata;
    logic        busy;
    logic        tick_miss;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [23:0] sh_m;

    always #5 clk = ~clk;

    led_seq_ctrl #(.DIV_W(16)) dut (
        .clk(clk), .ledrst(ledrst), .cpu_req(cpu_req), .cpu_data(cpu_data), .cpu_ack(cpu_ack),
        .mode(mode), .tick_div(tick_div), .led_cs(led_cs), .led_write(led_write),
        .led_addr(led_addr), .led_wdata(led_wdata), .busy(busy), .tick_miss(tick_miss)
    );

    typedef struct {
        logic        req;
        logic [23:0] data;
        logic [1:0]  md;
        logic [15:0] div;
        logic        e_cs;
        logic [1:0]  e_addr;
        logic [15:0] e_wdata;
        logic        e_ack;
        logic        e_busy;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic req, input logic [23:0] data, input logic [1:0] md, input logic [15:0] div,
                       input logic e_cs, input logic [1:0] e_addr, input logic [15:0] e_wdata,
                       input logic e_ack, input logic e_busy);
        vec_t v;
        v.req = req; v.data = data; v.md = md; v.div = div;
        v.e_cs = e_cs; v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_ack = e_ack; v.e_busy = e_busy;
        tbl.push_back(v);
    endtask

    task automatic step_chk(input string nm, input logic e_cs, input logic [1:0] e_addr,
                            input logic [15:0] e_wdata, input logic e_ack, input logic e_busy);
        @(posedge clk); #1;
        check(nm, 32'({led_cs, led_write, led_addr, led_wdata, cpu_ack, busy}),
                  32'({e_cs, e_cs, e_addr, e_wdata, e_ack, e_busy}));
    endtask

    task automatic check_hi(input string nm, input logic [23:0] val);
        check({nm, "_hi"}, 32'({led_cs, led_write, led_addr, led_wdata, busy, cpu_ack}),
                           32'({1'b1, 1'b1, 2'b10, 8'h00, val[23:16], 1'b1, 1'b0}));
    endtask

    // Waits for the next update and checks its low write, then its high write (or the skip)
    task automatic capture(input string nm, input logic [23:0] val, input logic is_cpu);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (led_cs) begin
                seen = 1'b1;
                break;
            end
        end
        check({nm, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({nm, "_lo"}, 32'({led_write, led_addr, led_wdata, busy}), 32'({1'b1, 2'b00, val[15:0], 1'b1}));
            check({nm, "_ack"}, 32'(cpu_ack), 32'(is_cpu));
            cpu_req = 1'b0;
            @(posedge clk); #1;
`ifdef LED_SEQ_SKIP_HI_EN
            if (val[23:16] == sh_m[23:16]) begin
                check({nm, "_skip"}, 32'({led_cs, led_write, busy, cpu_ack}), 32'd0);
            end else begin
                check_hi(nm, val);
            end
`else
            check_hi(nm, val);
`endif
            sh_m = val;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic seen;
        ledrst = 1'b1; cpu_req = 1'b0; cpu_data = 24'h0; mode = 2'b00; tick_div = 16'd0;
        sh_m = 24'h0;
        #12;
        check("reset_outputs", 32'({led_cs, led_write, led_addr, led_wdata, cpu_ack, busy, tick_miss}), 32'd0);
        @(negedge clk);
        ledrst = 1'b0;

        // CPU write A51234, then base 0000FF and blink with period 4 (first tick writes 0)
        add(1'b1, 24'hA5_1234, 2'b00, 16'd0, 1'b1, 2'b00, 16'h1234, 1'b1, 1'b1);
        add(1'b0, 24'h00_0000, 2'b00, 16'd0, 1'b1, 2'b10, 16'h00A5, 1'b0, 1'b1);
        add(1'b0, 24'h00_0000, 2'b00, 16'd0, 1'b0, 2'b10, 16'h00A5, 1'b0, 1'b0);
        add(1'b1, 24'h00_00FF, 2'b00, 16'd0, 1'b1, 2'b00, 16'h00FF, 1'b1, 1'b1);
        add(1'b0, 24'h00_0000, 2'b00, 16'd0, 1'b1, 2'b10, 16'h0000, 1'b0, 1'b1);
        add(1'b0, 24'h00_0000, 2'b00, 16'd0, 1'b0, 2'b10, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) add(1'b0, 24'h0, 2'b01, 16'd4, 1'b0, 2'b10, 16'h0000, 1'b0, 1'b0);
`ifdef LED_SEQ_SKIP_HI_EN
        add(1'b0, 24'h0, 2'b01, 16'd4, 1'b1, 2'b00, 16'h0000, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) add(1'b0, 24'h0, 2'b01, 16'd4, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0);
        add(1'b0, 24'h0, 2'b01, 16'd4, 1'b1, 2'b00, 16'h00FF, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) add(1'b0, 24'h0, 2'b01, 16'd4, 1'b0, 2'b00, 16'h00FF, 1'b0, 1'b0);
        add(1'b0, 24'h0, 2'b01, 16'd4, 1'b1, 2'b00, 16'h0000, 1'b0, 1'b1);
        add(1'b0, 24'h0, 2'b01, 16'd4, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0);
        add(1'b0, 24'h0, 2'b01, 16'd4, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0);
        add(1'b0, 24'h0, 2'b00, 16'd0, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0);
`else
        add(1'b0, 24'h0, 2'b01, 16'd4, 1'b1, 2'b00, 16'h0000, 1'b0, 1'b1);
        add(1'b0, 24'h0, 2'b01, 16'd4, 1'b1, 2'b10, 16'h0000, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) add(1'b0, 24'h0, 2'b01, 16'd4, 1'b0, 2'b10, 16'h0000, 1'b0, 1'b0);
        add(1'b0, 24'h0, 2'b01, 16'd4, 1'b1, 2'b00, 16'h00FF, 1'b0, 1'b1);
        add(1'b0, 24'h0, 2'b01, 16'd4, 1'b1, 2'b10, 16'h0000, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) add(1'b0, 24'h0, 2'b01, 16'd4, 1'b0, 2'b10, 16'h0000, 1'b0, 1'b0);
        add(1'b0, 24'h0, 2'b01, 16'd4, 1'b1, 2'b00, 16'h0000, 1'b0, 1'b1);
        add(1'b0, 24'h0, 2'b01, 16'd4, 1'b1, 2'b10, 16'h0000, 1'b0, 1'b1);
        add(1'b0, 24'h0, 2'b01, 16'd4, 1'b0, 2'b10, 16'h0000, 1'b0, 1'b0);
        add(1'b0, 24'h0, 2'b00, 16'd0, 1'b0, 2'b10, 16'h0000, 1'b0, 1'b0);
`endif
        for (int i = 0; i < tbl.size(); i++) begin
            cpu_req = tbl[i].req; cpu_data = tbl[i].data; mode = tbl[i].md; tick_div = tbl[i].div;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i),
                  32'({led_cs, led_write, led_addr, led_wdata, cpu_ack, busy, tick_miss}),
                  32'({tbl[i].e_cs, tbl[i].e_cs, tbl[i].e_addr, tbl[i].e_wdata, tbl[i].e_ack, tbl[i].e_busy, 1'b0}));
        end
        sh_m = 24'h00_0000;

        // Rotate: CPU seeds 800001, then ticks every 3 cycles
        cpu_req = 1'b1; cpu_data = 24'h80_0001;
        capture("t3_cpu", 24'h80_0001, 1'b1);
        mode = 2'b10; tick_div = 16'd3;
        capture("t3_rot1", 24'h00_0003, 1'b0);
        capture("t3_rot2", 24'h00_0006, 1'b0);
        capture("t3_rot3", 24'h00_000C, 1'b0);
        mode = 2'b00; tick_div = 16'd0;
        repeat (4) @(posedge clk);
        #1;

        // CPU request meets a pending tick in IDLE: CPU first, tick rotates the new pattern right after
        mode = 2'b10; tick_div = 16'd3; cpu_req = 1'b1; cpu_data = 24'h12_3456;
        step_chk("t4_d1_lo", 1'b1, 2'b00, 16'h3456, 1'b1, 1'b1);
        cpu_data = 24'h40_0001;
        step_chk("t4_d1_hi", 1'b1, 2'b10, 16'h0012, 1'b0, 1'b1);
        step_chk("t4_idle1", 1'b0, 2'b10, 16'h0012, 1'b0, 1'b0);
        tick_div = 16'd0;
        step_chk("t4_d2_lo", 1'b1, 2'b00, 16'h0001, 1'b1, 1'b1);
        cpu_req = 1'b0;
        step_chk("t4_d2_hi", 1'b1, 2'b10, 16'h0040, 1'b0, 1'b1);
        step_chk("t4_idle2", 1'b0, 2'b10, 16'h0040, 1'b0, 1'b0);
        step_chk("t4_tk_lo", 1'b1, 2'b00, 16'h0002, 1'b0, 1'b1);
        step_chk("t4_tk_hi", 1'b1, 2'b10, 16'h0080, 1'b0, 1'b1);
        step_chk("t4_idle3", 1'b0, 2'b10, 16'h0080, 1'b0, 1'b0);
        check("t4_no_miss", 32'(tick_miss), 32'd0);
        mode = 2'b00;

        // Tick every cycle overruns the scheduler; then reset asynchronously inside WR_LO
        mode = 2'b10; tick_div = 16'd1;
        seen = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            if (tick_miss) begin
                seen = 1'b1;
                break;
            end
        end
        check("t5_miss_rise", 32'(seen), 32'd1);
        for (int n = 0; n < 5; n++) begin
            @(posedge clk); #1;
            check("t5_miss_sticky", 32'(tick_miss), 32'd1);
        end
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (led_cs && (led_addr == 2'b00) && busy) begin
                seen = 1'b1;
                break;
            end
        end
        check("t5_found_wr_lo", 32'(seen), 32'd1);
        #2 ledrst = 1'b1;
        #1;
        check("t5_async_rst", 32'({led_cs, led_write, led_addr, led_wdata, cpu_ack, busy, tick_miss}), 32'd0);
        @(negedge clk);
        mode = 2'b00; tick_div = 16'd0;
        @(negedge clk);
        ledrst = 1'b0;
        sh_m = 24'h00_0000;

        // Same high byte twice: second update may drop its high write
        cpu_req = 1'b1; cpu_data = 24'h11_0000;
        capture("t6_first", 24'h11_0000, 1'b1);
        cpu_req = 1'b1; cpu_data = 24'h11_2222;
        capture("t6_second", 24'h11_2222, 1'b1);
        step_chk("t6_idle", 1'b0, led_addr, led_wdata, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
